// File: rtl/io_port_peripheral.sv
// I/O peripheral on the processor In/Out/Int lines: RX FIFO feeding the In port,
// TX FIFO fed by the Out port, and a paced interrupt request for pending input.
module io_port_peripheral #(
    parameter int DEPTH     = 4,
    parameter int INT_WIDTH = 2,
    parameter int INT_GAP   = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [15:0]              ext_data,
    input  logic                     ext_valid,
    output logic                     ext_ready,
    output logic [15:0]              cpu_in,
    input  logic                     cpu_in_rd,
    output logic                     cpu_int,
    input  logic                     int_en,
    input  logic [15:0]              cpu_out,
    input  logic                     cpu_out_wr,
    output logic [15:0]              tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     tx_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL       = CW'(DEPTH);
    localparam logic [3:0]    WIDTH_LAST = 4'(INT_WIDTH - 1);
    localparam logic [3:0]    GAP_LAST   = (INT_GAP > 0) ? 4'(INT_GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT_ACK,
        S_GAP
    } int_state_t;

    // ---------------------------------------------------------------- RX FIFO
    logic [15:0]   rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr;
    logic [AW-1:0] rx_rd_ptr;
    logic          rx_push;
    logic          rx_pop;

    // Readiness comes from the registered count only, so a same-cycle pop never frees a full FIFO.
    assign ext_ready = (rx_count != FULL);
    assign rx_push   = ext_valid & ext_ready;
    assign rx_pop    = cpu_in_rd & (rx_count != '0);
    assign cpu_in    = (rx_count != '0) ? rx_mem[rx_rd_ptr] : '0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= ext_data;
    end

    // ---------------------------------------------------------------- TX FIFO
    logic [15:0]   tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr;
    logic [AW-1:0] tx_rd_ptr;
    logic          tx_full;
    logic          tx_push;
    logic          tx_pop;

    assign tx_full  = (tx_count == FULL);
    assign tx_valid = (tx_count != '0);
    assign tx_push  = cpu_out_wr & ~tx_full;
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_data  = tx_valid ? tx_mem[tx_rd_ptr] : '0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            tx_wr_ptr   <= '0;
            tx_rd_ptr   <= '0;
            tx_count    <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (cpu_out_wr && tx_full) tx_overflow <= 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= cpu_out;
    end

    // ---------------------------------------------------------- interrupt FSM
    int_state_t state;
    int_state_t state_next;
    logic [3:0] width_cnt;
    logic [3:0] width_cnt_next;
    logic [3:0] gap_cnt;
    logic [3:0] gap_cnt_next;
    logic       ack_seen;
    logic       ack_seen_next;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_IDLE;
            width_cnt <= '0;
            gap_cnt   <= '0;
            ack_seen  <= 1'b0;
            cpu_int   <= 1'b0;
        end else begin
            state     <= state_next;
            width_cnt <= width_cnt_next;
            gap_cnt   <= gap_cnt_next;
            ack_seen  <= ack_seen_next;
            cpu_int   <= (state_next == S_ASSERT);
        end
    end

    always_comb begin
        state_next     = state;
        width_cnt_next = width_cnt;
        gap_cnt_next   = gap_cnt;
        ack_seen_next  = ack_seen;
        unique case (state)
            S_IDLE: begin
                if (int_en && (rx_count != '0)) begin
                    state_next     = S_ASSERT;
                    width_cnt_next = '0;
                    ack_seen_next  = 1'b0;
                end
            end
            S_ASSERT: begin
                // A pop inside the pulse counts as the acknowledge; the pulse still runs full width.
                if (width_cnt == WIDTH_LAST) begin
                    gap_cnt_next = '0;
                    if (ack_seen || rx_pop)
                        state_next = (INT_GAP == 0) ? S_IDLE : S_GAP;
                    else
                        state_next = S_WAIT_ACK;
                end else begin
                    width_cnt_next = width_cnt + 1'b1;
                    if (rx_pop) ack_seen_next = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (rx_pop) begin
                    gap_cnt_next = '0;
                    state_next   = (INT_GAP == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_next = S_IDLE;
                else
                    gap_cnt_next = gap_cnt + 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
